// File: rtl/exprom_loader_if.sv
// Byte-stream input and four-lane ROM write bus of the expansion-ROM loader.
interface exprom_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] rom_dinp;
  logic [8:0] rom_address;
  logic [3:0] rom_wren;
  logic [3:0] rom_enable;

  // Loader side: consumes the stream, drives the bank write port.
  modport master (
    input  s_data, s_valid,
    output s_ready, rom_dinp, rom_address, rom_wren, rom_enable
  );

  // Environment side: produces the stream, observes the bank writes.
  modport slave (
    output s_data, s_valid,
    input  s_ready, rom_dinp, rom_address, rom_wren, rom_enable
  );
endinterface

// File: rtl/exprom_loader.sv
// Expansion-ROM image loader: accepts a byte stream, checks the 55 AA <len>
// header and the mod-256 checksum, and writes byte k into byte lane k[1:0]
// at word address k[10:2] of four 512 x 8 banks.
module exprom_loader #(
  parameter int unsigned MAX_BLOCKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  exprom_loader_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err,
  output logic [11:0]           byte_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_e;

  localparam logic [7:0]  MAX_L   = 8'(MAX_BLOCKS);
  localparam logic [11:0] CNT_MAX = 12'd2048;

  state_e      state_q, state_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  len_q, len_d;
  logic        done_q, done_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  dinp_q, dinp_d;
  logic [8:0]  addr_q, addr_d;
  logic [3:0]  wren_q, wren_d;

  // Next state, counters, header/checksum checks and the registered write port.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    len_d      = len_q;
    done_d     = done_q;
    err_d      = err_q;
    dinp_d     = dinp_q;
    addr_d     = addr_q;
    wren_d     = '0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start && !abort) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          sum_d      = '0;
          len_d      = '0;
          err_d      = '0;
          done_d     = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = ERR;
        end else if (bus.s_valid) begin
          dinp_d     = bus.s_data;
          addr_d     = byte_cnt_q[10:2];
          wren_d     = 4'b0001 << byte_cnt_q[1:0];
          byte_cnt_d = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + 12'd1;
          sum_d      = sum_q + bus.s_data;
          if ((byte_cnt_q == 12'd0 && bus.s_data != 8'h55) ||
              (byte_cnt_q == 12'd1 && bus.s_data != 8'hAA)) begin
            err_d[0] = 1'b1;
            state_d  = ERR;
          end else if (byte_cnt_q == 12'd2) begin
            len_d = bus.s_data;
            if (bus.s_data == 8'h00 || bus.s_data > MAX_L) begin
              err_d[1] = 1'b1;
              state_d  = ERR;
            end
          end else if (byte_cnt_q > 12'd2 &&
                       {5'b0, byte_cnt_d} == {len_q, 9'b0}) begin
            if (sum_d == 8'h00) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              err_d[2] = 1'b1;
              state_d  = ERR;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      dinp_q     <= '0;
      addr_q     <= '0;
      wren_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      len_q      <= len_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dinp_q     <= dinp_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
    end
  end

  // Ready drops with abort so a byte offered in the abort cycle is never taken.
  assign bus.s_ready     = (state_q == LOAD) && !abort;
  assign bus.rom_dinp    = dinp_q;
  assign bus.rom_address = addr_q;
  assign bus.rom_wren    = wren_q;
  assign bus.rom_enable  = wren_q;
  assign busy            = (state_q == LOAD);
  assign done            = done_q;
  assign err             = err_q;
  assign byte_cnt        = byte_cnt_q;

endmodule

// File: doc/exprom_loader.md
EXPROM_LOADER -- requirements
Module: exprom_loader

Interface
REQ-001 SHALL have parameter MAX_BLOCKS, default 4, giving the maximum image size in 512-byte blocks (4 banks x 512 x 8 = 2048 bytes).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port start  input  1  pulse that begins a load.
REQ-005 SHALL have port abort  input  1  terminates a load in progress.
REQ-006 SHALL have port s_data  input  8  image byte stream.
REQ-007 SHALL have port s_valid  input  1  s_data is valid.
REQ-008 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-009 SHALL have port rom_dinp  output  8  write data, common to all four byte-lane banks.
REQ-010 SHALL have port rom_address  output  9  bank word address.
REQ-011 SHALL have port rom_wren  output  4  one write enable per byte lane (bit n = bank n).
REQ-012 SHALL have port rom_enable  output  4  bank enables, equal to rom_wren.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  last load completed with a valid image.
REQ-015 SHALL have port err  output  3  error flags {err_csum, err_len, err_sig}.
REQ-016 SHALL have port byte_cnt  output  12  bytes accepted in the current or last load.

Function
REQ-017 SHALL implement states IDLE, LOAD, DONE, ERR.
REQ-018 IDLE/DONE/ERR: start=1 and abort=0 SHALL go to LOAD next cycle, clearing byte_cnt, the checksum, err and done.
REQ-019 start in LOAD SHALL be ignored.
REQ-020 s_ready SHALL be 1 only in LOAD; a byte transfers when s_valid and s_ready are both 1.
REQ-021 Byte k (k = byte_cnt before acceptance) SHALL be written to lane k[1:0] at word address k[10:2].
REQ-022 The write SHALL appear one cycle after acceptance: registered rom_dinp, rom_address, and one-hot rom_wren, all valid for exactly one cycle. rom_wren SHALL be 0 in every other cycle.
REQ-023 Checksum SHALL be the 8-bit modulo-256 sum of all accepted bytes.
REQ-024 If byte 0 is not 0x55, or byte 1 is not 0xAA, the byte SHALL still be written, err_sig SHALL be set, and the state SHALL go to ERR.
REQ-025 Byte 2 SHALL be latched as the length L in blocks. If L = 0 or L > MAX_BLOCKS, the byte SHALL still be written, err_len SHALL be set, and the state SHALL go to ERR.
REQ-026 When byte_cnt reaches L*512 after an acceptance, the state SHALL leave LOAD: to DONE (done=1) if the checksum = 0x00, otherwise to ERR with err_csum set.
REQ-027 s_ready SHALL be 0 from the cycle after the final byte, so no byte beyond L*512 is ever accepted.
REQ-028 abort=1 in LOAD SHALL go to ERR with err=0 and no further writes; a write already registered from the previous cycle SHALL still complete.
REQ-029 start and abort asserted together SHALL be treated as abort; from IDLE this leaves the state unchanged.
REQ-030 busy SHALL be 1 exactly while in LOAD.
REQ-031 byte_cnt SHALL saturate at 2048 and never wrap.
REQ-032 done and err SHALL hold their values until the next accepted start or reset.
REQ-033 The checksum SHALL include byte 2 and all header bytes.

Reset
REQ-034 While rst_n=0 at a clk edge, the next state SHALL be IDLE with s_ready=0, rom_wren=0, rom_enable=0, rom_dinp=0, rom_address=0, busy=0, done=0, err=0, byte_cnt=0, checksum=0 and L=0.
REQ-035 Reset asserted mid-load SHALL abandon the load with no further writes and no flag set.

Verification
REQ-036 Valid 512-byte image (55 AA 01 ..., last byte chosen so the sum = 0), s_valid held 1 -> 512 single-lane writes, byte 4 at lane 0 address 1, done=1 and err=0 the cycle after byte 511, byte_cnt=512.
REQ-037 Image whose byte 0 = 0x4D -> one write to lane 0 address 0, err=3'b001, s_ready=0 thereafter, busy=0.
REQ-038 Header 55 AA 05 with MAX_BLOCKS=4 -> err=3'b010 after byte 2; L=00 -> same result.
REQ-039 1024-byte image (L=2) with checksum 0x01 -> 1024 writes, err=3'b100, done=0; s_valid pulsed 1-of-3 cycles -> identical bank contents and result.
REQ-040 abort at byte_cnt=100 -> no writes after byte 99's write, err=0, done=0; a subsequent start reloads from byte_cnt=0.
REQ-041 rst_n=0 at byte_cnt=300 -> all outputs zero the next cycle; start during busy has no effect (byte_cnt continues monotonically).
